// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: one 4-bit add slice, LSB nibble first, carry held
// in a register between nibbles. Result flags are captured with the last nibble.
//
// Handshake: an operand set transfers on a rising edge where in_valid and
// in_ready are both 1; a result transfers on a rising edge where out_valid
// and out_ready are both 1. in_ready is high only in IDLE and out_valid only
// in DONE, so the two never overlap and nothing is accepted in the DONE->IDLE
// cycle.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Z,
  output logic             carry,
  output logic             sign,
  output logic             parity,
  output logic             zero,
  output logic             overflow,
  output logic [1:0]       dbg_state
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [WIDTH-1:0] x_q, y_q;
  logic             cy_q;
  logic [CW-1:0]    cnt;

  logic [3:0]       xn, yn;
  logic [4:0]       sum5;
  logic [WIDTH-1:0] z_nxt;
  logic             last;
  int               idx;

  // Nibble slice: select the current nibble, add with the held carry and
  // build the Z value that results once this nibble is written.
  always_comb begin
    idx   = 4 * int'(cnt);
    xn    = x_q[idx +: 4];
    yn    = y_q[idx +: 4];
    sum5  = {1'b0, xn} + {1'b0, yn} + {4'b0000, cy_q};
    z_nxt = Z;
    z_nxt[idx +: 4] = sum5[3:0];
    last  = (cnt == CW'(NIB - 1));
  end

  // Next-state logic for IDLE -> RUN -> DONE -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Operand capture, per-nibble accumulation and final flag capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q      <= '0;
      y_q      <= '0;
      cy_q     <= 1'b0;
      cnt      <= '0;
      Z        <= '0;
      carry    <= 1'b0;
      sign     <= 1'b0;
      parity   <= 1'b0;
      zero     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_q  <= X;
            y_q  <= Y;
            cy_q <= Cin;
            cnt  <= '0;
          end
        end
        RUN: begin
          Z    <= z_nxt;
          cy_q <= sum5[4];
          cnt  <= cnt + 1'b1;
          if (last) begin
            carry    <= sum5[4];
            sign     <= z_nxt[WIDTH-1];
            parity   <= ~^z_nxt;
            zero     <= (z_nxt == '0);
            overflow <= (x_q[WIDTH-1] == y_q[WIDTH-1]) &&
                        (z_nxt[WIDTH-1] != x_q[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: arithmetic reference model with an expected
// queue, a per-cycle compare process and directed operand vectors.
module tb_nibble_serial_adder;

  localparam int W   = 16;
  localparam int NIB = W / 4;
  localparam int VW  = W + 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  X = '0;
  logic [W-1:0]  Y = '0;
  logic          Cin = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  Z;
  logic          carry, sign, parity, zero, overflow;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .X(X), .Y(Y), .Cin(Cin), .out_valid(out_valid), .out_ready(out_ready),
    .Z(Z), .carry(carry), .sign(sign), .parity(parity), .zero(zero),
    .overflow(overflow), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Packed result layout: {Z, carry, sign, parity, zero, overflow}
  function automatic logic [VW-1:0] model(input logic [W-1:0] x,
                                          input logic [W-1:0] y,
                                          input logic c);
    logic [W:0]   s;
    logic [W-1:0] z;
    s = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    z = s[W-1:0];
    return {z, s[W], z[W-1], ~^z, (z == '0),
            (x[W-1] == y[W-1]) && (z[W-1] != x[W-1])};
  endfunction

  logic [VW-1:0] dut_vec;
  assign dut_vec = {Z, carry, sign, parity, zero, overflow};

  // Transaction-level reference: phase 0 idle, 1..NIB busy, NIB+1 result held.
  logic [VW-1:0] exp_q[$];
  int            m_phase = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0;
      exp_q.delete();
    end else begin
      if (m_phase == 0) begin
        if (in_valid) begin
          exp_q.push_back(model(X, Y, Cin));
          m_phase = 1;
        end
      end else if (m_phase <= NIB) begin
        m_phase = m_phase + 1;
      end else if (out_ready) begin
        void'(exp_q.pop_front());
        m_phase = 0;
      end
    end
  end

  // Compare process: handshake outputs every cycle, result while valid.
  always @(negedge clk) begin
    checks++;
    if (in_ready !== (m_phase == 0)) begin
      errors++;
      $display("FAIL in_ready t=%0t got %b want %b", $time, in_ready, (m_phase == 0));
    end
    checks++;
    if (out_valid !== (m_phase == NIB + 1)) begin
      errors++;
      $display("FAIL out_valid t=%0t got %b want %b", $time, out_valid, (m_phase == NIB + 1));
    end
    if (m_phase == NIB + 1 && exp_q.size() > 0) begin
      checks++;
      if (dut_vec !== exp_q[0]) begin
        errors++;
        $display("FAIL result t=%0t got %h want %h", $time, dut_vec, exp_q[0]);
      end
    end
  end

  task automatic check_vec(input string name, input logic [VW-1:0] got,
                           input logic [VW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic scramble();
    X        = W'($urandom);
    Y        = W'($urandom);
    Cin      = 1'($urandom_range(0, 1));
    in_valid = 1'($urandom_range(0, 1));
  endtask

  // Present one operand set, wait for the result, hold it, then release it.
  task automatic run_op(input string name, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic c,
                        input logic [VW-1:0] want, input int hold);
    bit got;
    @(posedge clk); #1;
    X = x; Y = y; Cin = c; in_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (in_ready) begin got = 1; break; end
    end
    if (!got) begin
      errors++; checks++;
      $display("FAIL %s accept timeout got 0 want 1", name);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    scramble();
    got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) begin got = 1; break; end
      @(posedge clk); #1;
      scramble();
    end
    if (!got) begin
      errors++; checks++;
      $display("FAIL %s out_valid timeout got 0 want 1", name);
      in_valid = 1'b0;
      return;
    end
    check_vec(name, dut_vec, want);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      X = ~X;
      in_valid = ~in_valid;
      @(negedge clk);
      check_vec({name, "_hold"}, dut_vec, want);
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s_hold_in_ready got %b want 0", name, in_ready);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    // Model pins against hand-computed values
    check_vec("pin_2p3",     model(16'h0002, 16'h0003, 1'b0), {16'h0005, 5'b00100});
    check_vec("pin_ffffp1",  model(16'hFFFF, 16'h0001, 1'b0), {16'h0000, 5'b10110});
    check_vec("pin_7fffp1",  model(16'h7FFF, 16'h0001, 1'b0), {16'h8000, 5'b01001});
    check_vec("pin_8000pff", model(16'h8000, 16'hFFFF, 1'b0), {16'h7FFF, 5'b10001});
    check_vec("pin_ripple",  model(16'h0F0F, 16'h00F1, 1'b1), {16'h1001, 5'b00100});

    // Reset block
    repeat (3) @(posedge clk);
    #1;
    check_vec("reset_state", {dut_vec, in_ready, out_valid}, {{VW{1'b0}}, 2'b10});
    @(negedge clk);
    rst = 1'b0;

    run_op("add_2_3",     16'h0002, 16'h0003, 1'b0, {16'h0005, 5'b00100}, 0);
    run_op("wrap_ffff",   16'hFFFF, 16'h0001, 1'b0, {16'h0000, 5'b10110}, 0);
    run_op("ovf_pos",     16'h7FFF, 16'h0001, 1'b0, {16'h8000, 5'b01001}, 1);
    run_op("ovf_neg",     16'h8000, 16'hFFFF, 1'b0, {16'h7FFF, 5'b10001}, 0);
    run_op("ripple_hold", 16'h0F0F, 16'h00F1, 1'b1, {16'h1001, 5'b00100}, 3);
    run_op("min_neg",     16'h8000, 16'h8000, 1'b0, {16'h0000, 5'b10111}, 0);
    run_op("pattern",     16'h1234, 16'h4321, 1'b0, {16'h5555, 5'b00100}, 0);

    // Reset during RUN aborts the operation
    @(posedge clk); #1;
    X = 16'h1111; Y = 16'h2222; Cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_vec("reset_in_run", {dut_vec, in_ready, out_valid}, {{VW{1'b0}}, 2'b10});
    @(posedge clk); #1;
    rst = 1'b0;
    run_op("after_reset", 16'h00FF, 16'h0001, 1'b1, {16'h0101, 5'b00100}, 0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
